// File: rtl/axi_apb_pkg.sv
// Shared state encoding, response codes and constants for the
// AXI4-Lite to APB bridge.
package axi_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WRESP  = 3'd3,
      ST_RRESP  = 3'd4
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_rw_arbiter.sv
// Read/write request arbiter: eligibility, alternating priority and
// single-cycle ready pulses for the AXI address/data channels.
module axi_rw_arbiter (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic awvalid,
   input  logic wvalid,
   input  logic arvalid,
   output logic awready,
   output logic wready,
   output logic arready,
   output logic grant_wr,
   output logic grant_rd
);

   logic wr_first_q;
   logic wr_ok;
   logic rd_ok;

   // a write needs address and data presented together
   always_comb begin
      wr_ok    = en && awvalid && wvalid;
      rd_ok    = en && arvalid;
      grant_wr = wr_ok && (!rd_ok || wr_first_q);
      grant_rd = rd_ok && (!wr_ok || !wr_first_q);
      awready  = grant_wr;
      wready   = grant_wr;
      arready  = grant_rd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_first_q <= 1'b0;
      end else if (grant_wr) begin
         wr_first_q <= 1'b0;
      end else if (grant_rd) begin
         wr_first_q <= 1'b1;
      end
   end

endmodule

// File: rtl/axi4lite_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB master bridge.
// Optional ACCESS-phase timeout enabled by APB_BRIDGE_TIMEOUT_EN.
module axi4lite_apb_bridge
   import axi_apb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [2:0]        awprot,
   input  logic              wvalid,
   output logic              wready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wstrb,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [2:0]        arprot,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic [2:0]        pprot,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   output logic [3:0]        pstrb,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
`ifdef APB_BRIDGE_TIMEOUT_EN
   output logic              timeout_flag,
`endif
   input  logic              pslverr
);

   if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("axi4lite_apb_bridge: DATA_W must be 32, TIMEOUT_CYCLES >= 1");
   end

   state_t state_q;
   state_t state_d;
   logic   idle;
   logic   gnt_wr;
   logic   gnt_rd;
   logic   tmo;
   logic   acc_end;

   assign idle    = (state_q == ST_IDLE) && !reset;
   assign acc_end = (state_q == ST_ACCESS) && (pready || tmo);

   axi_rw_arbiter u_arb (
      .clock    (clock),
      .reset    (reset),
      .en       (idle),
      .awvalid  (awvalid),
      .wvalid   (wvalid),
      .arvalid  (arvalid),
      .awready  (awready),
      .wready   (wready),
      .arready  (arready),
      .grant_wr (gnt_wr),
      .grant_rd (gnt_rd)
   );

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             tflag_q;

   // fires on the last allowed ACCESS cycle if the slave is still stalling
   assign tmo = (state_q == ST_ACCESS) && !pready &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_flag = tflag_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         tflag_q <= 1'b0;
      end else begin
         if (state_q == ST_SETUP) begin
            cnt_q <= '0;
         end else if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (tmo) begin
            tflag_q <= 1'b1;
         end
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      psel    = 1'b0;
      penable = 1'b0;
      bvalid  = 1'b0;
      rvalid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_wr || gnt_rd) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel    = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready || tmo) begin
               state_d = pwrite ? ST_WRESP : ST_RRESP;
            end
         end
         ST_WRESP: begin
            bvalid = 1'b1;
            if (bready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RRESP: begin
            rvalid = 1'b1;
            if (rready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // request fields only change on a grant, so they hold through ACCESS
   always_ff @(posedge clock) begin
      if (reset) begin
         paddr  <= '0;
         pprot  <= '0;
         pwdata <= '0;
         pstrb  <= '0;
         pwrite <= 1'b0;
         rdata  <= '0;
         bresp  <= RESP_OKAY;
         rresp  <= RESP_OKAY;
      end else begin
         if (gnt_wr) begin
            paddr  <= awaddr;
            pprot  <= awprot;
            pwdata <= wdata;
            pstrb  <= wstrb;
            pwrite <= 1'b1;
         end else if (gnt_rd) begin
            paddr  <= araddr;
            pprot  <= arprot;
            pwdata <= '0;
            pstrb  <= '0;
            pwrite <= 1'b0;
         end
         if (acc_end) begin
            if (pwrite) begin
               bresp <= resp_of(pslverr || tmo);
            end else begin
               rresp <= resp_of(pslverr || tmo);
               rdata <= tmo ? DATA_W'(TIMEOUT_RDATA) : prdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Self-checking bench for axi4lite_apb_bridge: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_axi4lite_apb_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata, prdata;
   logic [2:0]  awprot, arprot, pprot;
   logic [3:0]  wstrb, pstrb;
   logic [1:0]  bresp, rresp;
   logic        psel, penable, pwrite, pready, pslverr;
`ifdef APB_BRIDGE_TIMEOUT_EN
   logic        timeout_flag;
`endif

   always #5 clock = ~clock;

   axi4lite_apb_bridge #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .awvalid (awvalid),
      .awready (awready),
      .awaddr  (awaddr),
      .awprot  (awprot),
      .wvalid  (wvalid),
      .wready  (wready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .bvalid  (bvalid),
      .bready  (bready),
      .bresp   (bresp),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .arprot  (arprot),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rresp   (rresp),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable),
      .pprot   (pprot),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .pready  (pready),
      .prdata  (prdata),
`ifdef APB_BRIDGE_TIMEOUT_EN
      .timeout_flag (timeout_flag),
`endif
      .pslverr (pslverr)
   );

   // APB slave: pready after wait_n stalled ACCESS cycles
   int          wait_n;
   int          acc_cnt;
   logic        slv_err;
   logic [31:0] slv_rdata;

   always @(posedge clock) begin
      if (reset || !(psel && penable)) acc_cnt <= 0;
      else acc_cnt <= acc_cnt + 1;
   end
   assign pready  = psel && penable && (acc_cnt >= wait_n);
   assign prdata  = slv_rdata;
   assign pslverr = slv_err;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; awprot = 0;
      araddr = 0; arprot = 0;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          wt;
      logic        err;
      logic [31:0] prd;
      int          lat;
      logic [1:0]  resp;
      logic [31:0] rd;
   } vec_t;

   vec_t tv[5];

   task automatic run_vec(input int idx, input vec_t v);
      int   seen;
      int   acc;
      logic stable;
      wait_n = v.wt; slv_err = v.err; slv_rdata = v.prd;
      tick();
      bready = 1; rready = 1;
      if (v.wr) begin
         awvalid = 1; wvalid = 1; awaddr = v.addr; awprot = v.prot;
         wdata = v.data; wstrb = v.strb;
      end else begin
         arvalid = 1; araddr = v.addr; arprot = v.prot;
      end
      @(negedge clock);
      chk($sformatf("vec%0d_grant", idx), {awready, wready, arready},
          v.wr ? 3'b110 : 3'b001);
      seen = -1; acc = 0; stable = 1;
      for (int c = 1; c <= 40 && seen < 0; c++) begin
         tick();
         awvalid = 0; wvalid = 0; arvalid = 0;
         @(negedge clock);
         if (psel) begin
            stable = stable && paddr == v.addr && pwrite == v.wr &&
                     pprot == v.prot && pstrb == (v.wr ? v.strb : 4'd0) &&
                     (!v.wr || pwdata == v.data);
         end
         if (psel && penable) acc++;
         if (bvalid || rvalid) begin
            seen = c;
            chk($sformatf("vec%0d_kind", idx), {bvalid, rvalid},
                v.wr ? 2'b10 : 2'b01);
            if (v.wr) chk($sformatf("vec%0d_bresp", idx), bresp, v.resp);
            else chk($sformatf("vec%0d_rresp_rdata", idx), {rresp, rdata},
                     {v.resp, v.rd});
         end
      end
      chk($sformatf("vec%0d_latency", idx), seen, v.lat);
      chk($sformatf("vec%0d_access_cycles", idx), acc, v.wt + 1);
      chk($sformatf("vec%0d_apb_stable", idx), stable, 1);
      tick();
      idle_inputs();
      @(negedge clock);
      chk($sformatf("vec%0d_valid_drop", idx), {bvalid, rvalid}, 0);
   endtask

   logic        gk[4];
   int          gc[4];
   int          n;
   logic        ok;
   int          seen;
   bit          pw, pr, busy, nxt_w, cw, eg_w, eg_r, cerr, ev;
   logic [31:0] ca, cd, crd;
   logic [3:0]  cs;
   logic [2:0]  cp;
   int          cg, cwt, ncomp, rel;

   initial begin
      tv[0] = '{wr:0, addr:32'h1000_0004, data:0, strb:0, prot:3'b000,
                wt:0, err:0, prd:32'h1234_5678, lat:3, resp:2'b00,
                rd:32'h1234_5678};
      tv[1] = '{wr:1, addr:32'h1000_0008, data:32'hCAFE_F00D,
                strb:4'b0011, prot:3'b010, wt:5, err:0, prd:0, lat:8,
                resp:2'b00, rd:0};
      tv[2] = '{wr:1, addr:32'h2000_0000, data:32'h0000_0001,
                strb:4'b1111, prot:3'b001, wt:0, err:1, prd:0, lat:3,
                resp:2'b10, rd:0};
      tv[3] = '{wr:0, addr:32'h2000_00FC, data:0, strb:0, prot:3'b101,
                wt:2, err:1, prd:32'h5555_AAAA, lat:5, resp:2'b10,
                rd:32'h5555_AAAA};
      tv[4] = '{wr:0, addr:32'hFFFF_FFFC, data:0, strb:0, prot:3'b111,
                wt:1, err:0, prd:32'hFFFF_FFFF, lat:4, resp:2'b00,
                rd:32'hFFFF_FFFF};

      idle_inputs();
      wait_n = 0; slv_err = 0; slv_rdata = 0;

      // reset: ready must stay low even with a request pending
      reset = 1; arvalid = 1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_arready", arready, 0);
      tick();
      reset = 0; arvalid = 0;
      @(negedge clock);
      chk("rst_ctrl", {awready, wready, arready, bvalid, rvalid,
                       psel, penable, pwrite}, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_misc", {pstrb, pprot, bresp, rresp}, 0);

      // simultaneous read and write from reset: R,W,R,W every 4 cycles
      tick();
      awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
      awaddr = 32'h0000_0100; wdata = 32'h1111_2222; wstrb = 4'hF;
      araddr = 32'h0000_0200;
      n = 0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) tick();
         @(negedge clock);
         if (arready || awready) begin
            if (n < 4) begin
               gk[n] = awready;
               gc[n] = c;
            end
            n++;
         end
      end
      tick();
      idle_inputs();
      chk("alt_count", n, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("alt_kind%0d", k), gk[k], k % 2);
         chk($sformatf("alt_cycle%0d", k), gc[k], 4 * k);
      end

      for (int i = 0; i < 5; i++) run_vec(i, tv[i]);

      // lone awvalid is never accepted
      wait_n = 0; slv_err = 0;
      tick();
      awvalid = 1; awaddr = 32'h3000_0010; awprot = 3'b000;
      wdata = 32'h0BAD_F00D; wstrb = 4'b1000; bready = 1;
      ok = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (awready || wready || arready) ok = 0;
         tick();
      end
      chk("aw_only_no_ready", ok, 1);
      wvalid = 1;
      @(negedge clock);
      chk("aw_w_grant", {awready, wready}, 2'b11);
      tick();
      awvalid = 0; wvalid = 0;
      tick(); tick();
      @(negedge clock);
      chk("aw_w_bvalid", {bvalid, bresp}, 3'b100);
      tick();
      idle_inputs();

      // SLVERR read with a stalled master; new read must wait
      slv_err = 1; slv_rdata = 32'hA5A5_0F0F;
      tick();
      arvalid = 1; araddr = 32'h4000_0000; arprot = 3'b011;
      @(negedge clock);
      chk("err_rd_grant", arready, 1);
      tick();
      arvalid = 0;
      tick(); tick();
      araddr = 32'h4000_0040; arvalid = 1; rready = 0;
      ok = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (!rvalid || rresp !== 2'b10 || rdata !== 32'hA5A5_0F0F ||
             arready) ok = 0;
         tick();
      end
      chk("err_rd_hold", ok, 1);
      arvalid = 0; rready = 1;
      @(negedge clock);
      chk("err_rd_handshake", {rvalid, rresp, rdata}, {3'b110, 32'hA5A5_0F0F});
      tick();
      rready = 0; slv_err = 0;
      @(negedge clock);
      chk("err_rd_done", rvalid, 0);

      // reset in ACCESS abandons the transfer
      wait_n = 1000;
      tick();
      awvalid = 1; wvalid = 1; awaddr = 32'h5000_0000;
      wdata = 32'h7777_7777; wstrb = 4'hF; bready = 1;
      @(negedge clock);
      chk("rst_mid_grant", awready, 1);
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      @(negedge clock);
      chk("rst_mid_access", {psel, penable}, 2'b11);
      tick();
      reset = 1;
      tick();
      reset = 0;
      @(negedge clock);
      chk("rst_mid_apb_drop", {psel, penable}, 0);
      ok = 1;
      for (int c = 0; c < 10; c++) begin
         tick();
         @(negedge clock);
         if (bvalid || rvalid || psel) ok = 0;
      end
      chk("rst_mid_no_resp", ok, 1);

`ifdef APB_BRIDGE_TIMEOUT_EN
      tick();
      awvalid = 1; wvalid = 1; awaddr = 32'h6000_0000; bready = 1;
      @(negedge clock);
      chk("tmo_grant", awready, 1);
      seen = -1;
      for (int c = 1; c <= 30 && seen < 0; c++) begin
         tick();
         awvalid = 0; wvalid = 0;
         @(negedge clock);
         if (bvalid) begin
            seen = c;
            chk("tmo_bresp", bresp, 2'b10);
         end
      end
      chk("tmo_latency", seen, 10);
      chk("tmo_flag", timeout_flag, 1);
      tick();
      idle_inputs();
`endif
      wait_n = 0;

      // randomized traffic against a transaction-level model
      tick();
      reset = 1;
      idle_inputs();
      tick();
      reset = 0;
      pw = 0; pr = 0; busy = 0; nxt_w = 0; ncomp = 0;
      cw = 0; cg = 0; cwt = 0; cerr = 0; ca = 0; cd = 0; crd = 0;
      cs = 0; cp = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         if (!pw && $urandom_range(0, 2) == 0) begin
            pw = 1; awaddr = $urandom; wdata = $urandom;
            wstrb = 4'($urandom); awprot = 3'($urandom);
         end
         if (!pr && $urandom_range(0, 2) == 0) begin
            pr = 1; araddr = $urandom; arprot = 3'($urandom);
         end
         awvalid = pw; wvalid = pw; arvalid = pr;
         bready = ($urandom_range(0, 1) == 1);
         rready = ($urandom_range(0, 1) == 1);
         @(negedge clock);
         eg_w = !busy && pw && (!pr || nxt_w);
         eg_r = !busy && pr && (!pw || !nxt_w);
         chk("rnd_ready", {awready, wready, arready}, {eg_w, eg_w, eg_r});
         if (busy) begin
            rel = cyc - cg;
            ev = (rel >= 3 + cwt);
            chk("rnd_apb_ctl", {psel, penable},
                {rel >= 1 && rel <= 2 + cwt, rel >= 2 && rel <= 2 + cwt});
            if (psel) chk("rnd_apb_req", {paddr, pwrite, pstrb, pprot},
                          {ca, cw, cs, cp});
            if (psel && cw) chk("rnd_pwdata", pwdata, cd);
            chk("rnd_valid", {bvalid, rvalid},
                ev ? (cw ? 2'b10 : 2'b01) : 2'b00);
            if (ev) begin
               if (cw) chk("rnd_bresp", bresp, cerr ? 2'b10 : 2'b00);
               else chk("rnd_rresp_rdata", {rresp, rdata},
                        {cerr ? 2'b10 : 2'b00, crd});
               if ((cw && bready) || (!cw && rready)) begin
                  busy = 0;
                  ncomp++;
               end
            end
         end else begin
            chk("rnd_idle", {psel, bvalid, rvalid}, 0);
            if (eg_w || eg_r) begin
               busy = 1; cw = eg_w; cg = cyc;
               ca = cw ? awaddr : araddr;
               cd = wdata;
               cs = cw ? wstrb : 4'd0;
               cp = cw ? awprot : arprot;
               cwt = $urandom_range(0, 3);
               cerr = ($urandom_range(0, 3) == 0);
               crd = $urandom;
               wait_n = cwt; slv_err = cerr; slv_rdata = crd;
               nxt_w = !cw;
               if (cw) pw = 0;
               else pr = 0;
            end
         end
      end
      chk("rnd_progress", ncomp >= 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4lite_apb_bridge.md
Name: axi4lite_apb_bridge

Overview:
- Converts single AXI4-Lite transactions from the CPU-side interconnect into APB3/APB4 transfers.
- Feeds the APB delay-calibration stage directly downstream; its APB master port is that stage's APB slave port.
- One outstanding transaction at a time. Fair read/write arbitration. APB error is mapped to the AXI response code.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; fixed at 32 in this release.
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycle limit; used only with the optional feature.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- awvalid in 1, awready out 1, awaddr in ADDR_W, awprot in 3: AXI write address channel.
- wvalid in 1, wready out 1, wdata in DATA_W, wstrb in 4: AXI write data channel.
- bvalid out 1, bready in 1, bresp out 2: AXI write response channel.
- arvalid in 1, arready out 1, araddr in ADDR_W, arprot in 3: AXI read address channel.
- rvalid out 1, rready in 1, rdata out DATA_W, rresp out 2: AXI read data channel.
- paddr out ADDR_W, psel out 1, penable out 1, pprot out 3, pwrite out 1, pwdata out DATA_W, pstrb out 4: APB request.
- pready in 1, prdata in DATA_W, pslverr in 1: APB response.

Behaviour:
- Reset: all AXI ready/valid outputs 0; psel, penable, pwrite 0; paddr, pwdata, pstrb, pprot, rdata 0; bresp, rresp 0; state IDLE; priority flag = read-first.
- States: IDLE, SETUP, ACCESS, WRESP, RRESP.
- IDLE, write eligible: awvalid && wvalid, both in the same cycle. A lone awvalid or lone wvalid is never accepted.
- IDLE, read eligible: arvalid.
- IDLE, both eligible: grant the side opposite to the previous grant. After reset, read wins.
- IDLE, on grant: pulse the chosen ready(s) for exactly one cycle (awready+wready together, or arready). Register address, prot, data and strobe. Go to SETUP.
- SETUP: psel=1, penable=0. Next state ACCESS.
- ACCESS: psel=1, penable=1. Hold until pready=1.
  - On pready: capture prdata/pslverr. Drop psel/penable next cycle.
  - Go to WRESP if write, RRESP if read.
- APB request stability: paddr, pwrite, pwdata, pstrb, pprot are stable from SETUP through the last ACCESS cycle.
- Read strobe: pstrb=0 for reads.
- Response code: pslverr=1 gives resp 2'b10 (SLVERR); otherwise 2'b00 (OKAY).
- WRESP / RRESP:
  - bvalid (or rvalid) is 1 with the captured resp/data.
  - Held until bready (or rready); data and resp are held stable meanwhile.
  - On handshake, go to IDLE.
  - No new AXI channel is accepted until the response handshake completes.
- Minimum latency, pready=1 on first ACCESS cycle: grant at cycle 0, SETUP cycle 1, ACCESS cycle 2, valid asserted cycle 3. Back-to-back transactions are 4 cycles apart when the master is always ready.
- Reset mid-transaction: immediate return to reset values at the next edge. Any in-flight APB transfer is abandoned and no AXI response is issued.
- Unknown state encoding recovers to IDLE.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments every ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with pready still 0, drop psel/penable and respond SLVERR. rdata=32'hDEADBEEF for reads.
  - Assert a sticky timeout_flag output, cleared only by reset.
- Undefined: no counter and no timeout_flag port; ACCESS waits indefinitely.

Decomposition:
- Shared package axi_apb_pkg:
  - State enum.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Timeout read pattern 32'hDEADBEEF.
- One natural sub-module: axi_rw_arbiter. It handles eligibility, alternating priority and the one-cycle ready pulses. All else lives in the top.

Test Plan:
- Single read: araddr=32'h1000_0004, prdata=32'h1234_5678, pready=1 on first ACCESS, rready=1 -> rvalid at cycle 3, rdata=32'h1234_5678, rresp=0, pstrb=0.
- Write with wait states: awaddr=32'h1000_0008, wdata=32'hCAFE_F00D, wstrb=4'b0011, pready low 5 ACCESS cycles -> pwdata, pstrb, paddr stable for all 6 ACCESS cycles; bvalid 1 cycle after pready; bresp=0.
- Simultaneous read and write every cycle from reset -> grants alternate R,W,R,W; the first is read.
- AW-only for 10 cycles, then wvalid -> awready stays 0 until wvalid; the grant occurs on the first cycle both are high.
- pslverr=1 on a read, with rready held low 3 cycles -> rresp=2'b10; rvalid and rdata stable until rready; no arready meanwhile.
- Reset asserted in ACCESS -> next cycle psel=0, penable=0, no bvalid/rvalid. With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready never asserted -> SLVERR after 8 ACCESS cycles; timeout_flag=1.
